// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU, its arbiter front end, the instruction
// decoder and the bench.
//   ALU_*   : 3-bit ALU control codes. 3'b100, 3'b110 and 3'b111 are undefined
//             and make the ALU return zero.
//   NUM_REQ : number of requesters sharing the ALU.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam int NUM_REQ = 2;

  // True when the control code selects a defined operation.
  function automatic logic alu_ctrl_defined(input logic [2:0] ctrl);
    return (ctrl == ALU_ADD) || (ctrl == ALU_SUB) || (ctrl == ALU_AND) ||
           (ctrl == ALU_OR)  || (ctrl == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational ALU.
//   ctrl_i   : operation code (alu_pkg encoding)
//   op1_i    : first operand
//   op2_i    : second operand
//   result_o : ADD/SUB wrap modulo 2^DATA_WIDTH, SLT is an unsigned compare,
//              undefined codes give zero
//   eq_o     : op1_i == op2_i, independent of ctrl_i
// -----------------------------------------------------------------------------
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            ctrl_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  eq_o
);

  always_comb begin
    result_o = '0;
    unique case (ctrl_i)
      ALU_ADD: result_o = op1_i + op2_i;
      ALU_SUB: result_o = op1_i - op2_i;
      ALU_AND: result_o = op1_i & op2_i;
      ALU_OR:  result_o = op1_i | op2_i;
      ALU_SLT: result_o = {{(DATA_WIDTH-1){1'b0}}, (op1_i < op2_i)};
      default: result_o = '0;
    endcase
  end

  assign eq_o = (op1_i == op2_i);

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between two requesters with a round-robin arbiter and a
// registered, backpressured response slot per requester.
//   clk, rst_n          : clock, asynchronous active-low reset
//   reqN_valid/_ready   : request handshake (ready == grant for N)
//   reqN_ctrl/_op1/_op2 : operation presented by requester N
//   rspN_valid/_ready   : response handshake for slot N
//   rspN_result/_eq     : registered ALU result and EQ flag for slot N
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. reqN_ready depends combinationally on reqN_valid, so a
// requester must never derive its valid from ready. A response slot stays
// valid, with result/eq stable, until rspN_ready is seen high.
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [2:0]            req0_ctrl,
  input  logic [DATA_WIDTH-1:0] req0_op1,
  input  logic [DATA_WIDTH-1:0] req0_op2,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_result,
  output logic                  rsp0_eq,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [2:0]            req1_ctrl,
  input  logic [DATA_WIDTH-1:0] req1_op1,
  input  logic [DATA_WIDTH-1:0] req1_op2,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_result,
  output logic                  rsp1_eq
);

  logic                  last_grant_q, last_grant_d;
  logic                  rsp0_valid_q, rsp1_valid_q;
  logic [DATA_WIDTH-1:0] rsp0_result_q, rsp1_result_q;
  logic                  rsp0_eq_q, rsp1_eq_q;

  logic                  slot_free0, slot_free1;
  logic                  elig0, elig1;
  logic                  grant0, grant1;

  logic [2:0]            alu_ctrl;
  logic [DATA_WIDTH-1:0] alu_op1, alu_op2, alu_result;
  logic                  alu_eq;

  // A slot can take a new result if it is empty or is being drained now.
  assign slot_free0 = !rsp0_valid_q || rsp0_ready;
  assign slot_free1 = !rsp1_valid_q || rsp1_ready;

  // rst_n gates eligibility so no handshake is offered while held in reset.
  assign elig0 = rst_n && req0_valid && slot_free0;
  assign elig1 = rst_n && req1_valid && slot_free1;

  // On a tie the requester that did not win last time gets the ALU.
  assign grant0 = elig0 && (!elig1 || last_grant_q);
  assign grant1 = elig1 && (!elig0 || !last_grant_q);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant0) last_grant_d = 1'b0;
    else if (grant1) last_grant_d = 1'b1;
  end

  // Idle ALU inputs are parked at zero to keep them from toggling.
  always_comb begin
    alu_ctrl = ALU_ADD;
    alu_op1  = '0;
    alu_op2  = '0;
    if (grant0) begin
      alu_ctrl = req0_ctrl;
      alu_op1  = req0_op1;
      alu_op2  = req0_op2;
    end else if (grant1) begin
      alu_ctrl = req1_ctrl;
      alu_op1  = req1_op1;
      alu_op2  = req1_op2;
    end
  end

  alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .ctrl_i   (alu_ctrl),
    .op1_i    (alu_op1),
    .op2_i    (alu_op2),
    .result_o (alu_result),
    .eq_o     (alu_eq)
  );

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end

  // Response slot 0: a grant loads (overwriting a draining result), a drain
  // alone only clears valid so result/eq keep their stale values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_eq_q     <= 1'b0;
    end else if (grant0) begin
      rsp0_valid_q  <= 1'b1;
      rsp0_result_q <= alu_result;
      rsp0_eq_q     <= alu_eq;
    end else if (rsp0_ready) begin
      rsp0_valid_q  <= 1'b0;
    end
  end

  // Response slot 1: same behaviour as slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_eq_q     <= 1'b0;
    end else if (grant1) begin
      rsp1_valid_q  <= 1'b1;
      rsp1_result_q <= alu_result;
      rsp1_eq_q     <= alu_eq;
    end else if (rsp1_ready) begin
      rsp1_valid_q  <= 1'b0;
    end
  end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_eq     = rsp0_eq_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_eq     = rsp1_eq_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed scenarios followed by random traffic for alu_arbiter. A reference
// model tracks, per requester, whether its response slot is full and what it
// holds, plus which requester was served last.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_eq;
  logic [2:0]   req0_ctrl;
  logic [W-1:0] req0_op1, req0_op2, rsp0_result;
  logic         req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_eq;
  logic [2:0]   req1_ctrl;
  logic [W-1:0] req1_op1, req1_op2, rsp1_result;

  alu_arbiter #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_ctrl   (req0_ctrl),
    .req0_op1    (req0_op1),
    .req0_op2    (req0_op2),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_eq     (rsp0_eq),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_ctrl   (req1_ctrl),
    .req1_op1    (req1_op1),
    .req1_op2    (req1_op2),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_eq     (rsp1_eq)
  );

  // ---------------- scoreboard / model state ----------------
  int           errors = 0;
  int           checks = 0;
  logic         m_full [NUM_REQ];
  logic [W-1:0] m_res  [NUM_REQ];
  logic         m_eq   [NUM_REQ];
  int           m_last_served;
  logic         obs_g0, obs_g1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [2:0] c, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint unsigned ua, ub, mod;
    ua  = longint'(a);
    ub  = longint'(b);
    mod = 64'd1 << W;
    case (c)
      3'b000:  return W'((ua + ub) % mod);
      3'b001:  return W'((ua + mod - ub) % mod);
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return (ua < ub) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NUM_REQ; n++) begin
      m_full[n] = 1'b0;
      m_res[n]  = '0;
      m_eq[n]   = 1'b0;
    end
    m_last_served = 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int n, input logic v, input logic [2:0] c,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    if (n == 0) begin
      req0_valid = v; req0_ctrl = c; req0_op1 = a; req0_op2 = b;
    end else begin
      req1_valid = v; req1_ctrl = c; req1_op1 = a; req1_op2 = b;
    end
  endtask

  task automatic drive_rsp(input logic r0, input logic r1);
    rsp0_ready = r0;
    rsp1_ready = r1;
  endtask

  task automatic check_slots(input string tag);
    chk({tag, ".v0"}, W'(rsp0_valid), W'(m_full[0]));
    chk({tag, ".r0"}, rsp0_result, m_res[0]);
    chk({tag, ".e0"}, W'(rsp0_eq), W'(m_eq[0]));
    chk({tag, ".v1"}, W'(rsp1_valid), W'(m_full[1]));
    chk({tag, ".r1"}, rsp1_result, m_res[1]);
    chk({tag, ".e1"}, W'(rsp1_eq), W'(m_eq[1]));
  endtask

  // One clock: check offered grants mid-cycle, advance the model, then check
  // the response slots just after the edge. Inputs must be stable meanwhile.
  task automatic step(input string tag);
    logic want0, want1;
    int   winner;
    @(negedge clk);
    want0  = rst_n && req0_valid && (!m_full[0] || rsp0_ready);
    want1  = rst_n && req1_valid && (!m_full[1] || rsp1_ready);
    winner = -1;
    if (want0 && want1) winner = (m_last_served == 0) ? 1 : 0;
    else if (want0)     winner = 0;
    else if (want1)     winner = 1;
    obs_g0 = req0_ready;
    obs_g1 = req1_ready;
    chk({tag, ".rdy0"}, W'(req0_ready), W'(winner == 0));
    chk({tag, ".rdy1"}, W'(req1_ready), W'(winner == 1));
    if (rsp0_ready) m_full[0] = 1'b0;
    if (rsp1_ready) m_full[1] = 1'b0;
    if (winner == 0) begin
      m_full[0] = 1'b1;
      m_res[0]  = ref_result(req0_ctrl, req0_op1, req0_op2);
      m_eq[0]   = (req0_op1 == req0_op2);
    end else if (winner == 1) begin
      m_full[1] = 1'b1;
      m_res[1]  = ref_result(req1_ctrl, req1_op1, req1_op2);
      m_eq[1]   = (req1_op1 == req1_op2);
    end
    if (winner >= 0) m_last_served = winner;
    @(posedge clk);
    #1;
    check_slots(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk({tag, ".rdy0"}, W'(req0_ready), '0);
    chk({tag, ".rdy1"}, W'(req1_ready), '0);
    @(posedge clk);
    #1;
    check_slots(tag);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] a, b;

    rst_n = 1'b0;
    drive_rsp(1'b1, 1'b1);
    drive_req(0, 1'b1, ALU_ADD, 32'd1, 32'd2);
    drive_req(1, 1'b1, ALU_ADD, 32'd3, 32'd4);
    @(posedge clk);
    #1;

    // 1: reset with requests pending, then tie goes to req0
    do_reset("t1.rst");
    step("t1.tie");
    chk("t1.first_grant", W'(obs_g0), W'(1));

    // 2: single ADD on req0
    do_reset("t2.rst");
    drive_req(1, 1'b0, ALU_ADD, '0, '0);
    drive_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
    step("t2.add");
    chk("t2.ready", W'(obs_g0), W'(1));
    chk("t2.result", rsp0_result, 32'd12);
    chk("t2.eq", W'(rsp0_eq), W'(0));

    // 3: contention, grants alternate 0,1,0,1
    do_reset("t3.rst");
    drive_req(0, 1'b1, ALU_SUB, 32'd9, 32'd9);
    drive_req(1, 1'b1, ALU_SLT, 32'd3, 32'd4);
    for (int i = 0; i < 4; i++) begin
      step("t3.cont");
      chk("t3.order", W'(obs_g0), W'(i % 2 == 0));
    end
    chk("t3.r0", rsp0_result, 32'd0);
    chk("t3.e0", W'(rsp0_eq), W'(1));
    chk("t3.r1", rsp1_result, 32'd1);
    chk("t3.e1", W'(rsp1_eq), W'(0));

    // 4: backpressure on slot 1 while req0 keeps being served
    drive_rsp(1'b1, 1'b0);
    drive_req(0, 1'b1, ALU_ADD, 32'd10, 32'd20);
    drive_req(1, 1'b1, ALU_AND, 32'hFF, 32'h0F);
    for (int i = 0; i < 3; i++) begin
      step("t4.bp");
      chk("t4.blocked1", W'(obs_g1), W'(0));
      chk("t4.served0", W'(obs_g0), W'(1));
    end
    drive_req(0, 1'b0, ALU_ADD, '0, '0);
    drive_req(1, 1'b1, ALU_OR, 32'hF0, 32'h0F);
    drive_rsp(1'b1, 1'b1);
    step("t4.refill");
    chk("t4.accept", W'(obs_g1), W'(1));
    chk("t4.result", rsp1_result, 32'hFF);
    chk("t4.valid", W'(rsp1_valid), W'(1));
    drive_req(1, 1'b0, ALU_ADD, '0, '0);
    step("t4.drain");
    chk("t4.stale", rsp1_result, 32'hFF);

    // 6: undefined control and wrap-around (slots empty, held afterwards)
    drive_rsp(1'b0, 1'b0);
    drive_req(0, 1'b1, 3'b111, 32'd6, 32'd6);
    drive_req(1, 1'b1, ALU_ADD, 32'hFFFF_FFFF, 32'd1);
    step("t6.a");
    step("t6.b");
    chk("t6.undef_r", rsp0_result, 32'd0);
    chk("t6.undef_e", W'(rsp0_eq), W'(1));
    chk("t6.wrap_r", rsp1_result, 32'd0);
    chk("t6.wrap_e", W'(rsp1_eq), W'(0));

    // 5: reset in the middle of a granted op
    drive_req(0, 1'b0, ALU_ADD, '0, '0);
    drive_req(1, 1'b1, ALU_AND, 32'hFF, 32'h0F);
    drive_rsp(1'b1, 1'b1);
    @(negedge clk);
    chk("t5.granted", W'(req1_ready), W'(1));
    rst_n = 1'b0;
    #1;
    chk("t5.async_v1", W'(rsp1_valid), W'(0));
    chk("t5.async_v0", W'(rsp0_valid), W'(0));
    model_reset();
    drive_req(1, 1'b0, ALU_ADD, '0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("t5.after");
    chk("t5.no_rsp", W'(rsp1_valid), W'(0));

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < NUM_REQ; n++) begin
        a = $urandom();
        b = ($urandom_range(0, 3) == 0) ? a : W'($urandom());
        drive_req(n, logic'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), a, b);
      end
      drive_rsp(logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 2) != 0));
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
